dlx_reduce_detect_pipe: RTL
===========================

Name: dlx_reduce_detect_pipe

Overview:
- Parametrised, pipelined successor to the DLX 32-bit all-ones/pull detector.
- Reduces a WIDTH-bit operand to a single hit bit: all-ones (mode 0) or all-zeros (mode 1), qualified by pullD.
- Two register stages with valid/ready flow control, a sticky hit flag and a saturating hit counter.
- Sits between the extended-DLX datapath (carry/wrap and zero detection) and control/status logic.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, 8, bits reduced per stage-1 group; NGRP = WIDTH/CHUNK partial results.
- CNT_W, 8, width of hit_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- Din  in  WIDTH  operand.
- pullD  in  1  qualifier, ANDed into the result.
- mode  in  1  0 = all-ones detect, 1 = all-zeros detect.
- out_valid  out  1  Dout valid.
- out_ready  in  1  consumer accepts Dout.
- Dout  out  1  hit result.
- sticky  out  1  set by any transferred hit.
- sticky_clr  in  1  clears sticky and hit_count.
- hit_count  out  CNT_W  saturating count of transferred hits.

Behaviour:
- Reset (asynchronous, active-high): s1_valid=0, out_valid=0, Dout=0, sticky=0, hit_count=0. in_ready=1 as soon as reset deasserts.
- Accept: an operand is accepted when in_valid && in_ready. Din, pullD and mode are sampled together at acceptance; mode is carried with its own data, so per-operand mode switching is legal.
- Stage 1: registers NGRP partial reductions. Group g = AND of its CHUNK bits (mode 0) or NOR of its CHUNK bits (mode 1). pullD and the valid bit are registered alongside.
- Stage 2 (output): Dout = AND of all partials AND pullD; out_valid set.
- Latency: exactly 2 cycles from acceptance to out_valid when there is no stall. Throughput: 1 operand per cycle.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready (combinational).
  - When out_valid && !out_ready: Dout and out_valid hold stable; stage 1 holds; at most 2 operands are in flight.
  - When out_valid && out_ready && !s1_valid: out_valid deasserts next cycle.
- Transfer: a transfer is out_valid && out_ready. Dout counts as a hit only on transfer; a stalled hit is never double-counted.
- sticky: set on a transfer with Dout=1. Cleared on sticky_clr. If both happen in the same cycle, set wins (sticky=1).
- hit_count: increments by 1 on a transfer with Dout=1 and saturates at 2^CNT_W-1. sticky_clr forces 0. If clear and hit happen in the same cycle, the result is 1.
- Reset mid-operation: all in-flight operands are discarded, with no output and no count.
- pullD=0 forces Dout=0 regardless of Din or mode, but the operand still flows through and produces out_valid.
- Flow-control outputs carry no X after reset. Din is not required to be stable while in_valid=0.

Test Plan:
- WIDTH=32, CHUNK=8, mode=0, pullD=1. Din=FFFFFFFF, then FFFFFFFE, then FFFFFFFF (out_ready=1) -> Dout 1,0,1 on cycles 2,3,4 after the first accept. hit_count=2, sticky=1.
- mode=1: Din=00000000, pullD=1 -> Dout=1. Din=00010000 -> Dout=0. Din=FFFFFFFF with pullD=0 in mode 0 -> Dout=0, out_valid=1.
- Backpressure: stream 4 all-ones operands, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, Dout stable, hit_count unchanged. Release -> 4 transfers total, hit_count=4.
- Saturation, CNT_W=2: 5 hits -> hit_count=3. sticky_clr together with a hit -> hit_count=1, sticky=1. sticky_clr alone -> 0, 0.
- Reset asserted asynchronously (mid-clock) with 2 operands in flight -> out_valid, Dout, sticky, hit_count = 0 immediately. No output after release until a new operand is accepted.
- Parametrisation: WIDTH=64, CHUNK=16, alternating mode per cycle with Din=0 / all-ones -> every result = 1, latency 2, one result per cycle.

Source files
------------

// File: rtl/dlx_reduce_detect_pipe.sv
// Two-stage pipelined all-ones / all-zeros reduction detector with valid/ready flow control,
// a sticky hit flag and a saturating hit counter.
module dlx_reduce_detect_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Din,
    input  logic             pullD,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Dout,
    output logic             sticky,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] hit_count
);

    localparam int unsigned NGRP = WIDTH / CHUNK;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("dlx_reduce_detect_pipe: WIDTH must be a multiple of CHUNK");
    end

    logic             s1_valid_q, s1_valid_d;
    logic [NGRP-1:0]  part_q, part_d;
    logic             s1_pull_q;
    logic             out_valid_q, out_valid_d;
    logic             dout_q, dout_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CHUNK-1:0] chunk;
    logic             s1_load, s2_load, xfer_hit;

    // Stage-1 group reduction: AND for all-ones, NOR for all-zeros.
    always_comb begin
        part_d = '0;
        chunk  = '0;
        for (int g = 0; g < int'(NGRP); g++) begin
            chunk     = Din[g*CHUNK +: CHUNK];
            part_d[g] = mode ? ~(|chunk) : (&chunk);
        end
    end

    always_comb begin
        in_ready = !s1_valid_q || !out_valid_q || out_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        xfer_hit = out_valid_q && out_ready && dout_q;

        s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);

        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            dout_d      = (&part_q) & s1_pull_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A hit in the same cycle as a clear wins over the clear.
        sticky_d = xfer_hit ? 1'b1 : (sticky_clr ? 1'b0 : sticky_q);

        cnt_d = cnt_q;
        if (sticky_clr) begin
            cnt_d = CNT_W'(xfer_hit);
        end else if (xfer_hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            part_q     <= '0;
            s1_pull_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                part_q    <= part_d;
                s1_pull_q <= pullD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Dout      = dout_q;
    assign sticky    = sticky_q;
    assign hit_count = cnt_q;

endmodule
